// File: rtl/countdown_timer.sv
// countdown_timer
// Loads a BCD HH:MM:SS preset and counts it down once per 1 Hz strobe,
// borrowing across seconds, minutes and hours. At zero it either stops in
// DONE and flags expiry, or, with AUTO_RELOAD set, reloads the last valid
// preset and keeps running. Digits drive the shared six-digit display path.

module countdown_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_1hz,
    input  logic        load,
    input  logic [23:0] preset,
    input  logic        start,
    input  logic        stop,
    output logic [3:0]  sec_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  min_tens,
    output logic [3:0]  hr_ones,
    output logic [3:0]  hr_tens,
    output logic        running,
    output logic        expired,
    output logic        expired_pulse,
    output logic        load_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state, state_nx;

    // Packed like the preset: {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}.
    logic [23:0] count, count_nx;
    logic [23:0] reload, reload_nx;
    logic [23:0] count_dec;
    logic        pulse_nx;
    logic        err_nx;
    logic        preset_ok;
    logic        count_zero;

    // One-second decrement with the clock-style borrow chain.
    // Callers never apply it to 00:00:00.
    function automatic logic [23:0] bcd_dec(input logic [23:0] c);
        logic [23:0] d;
        d = c;
        if (d[3:0] != 4'd0) begin
            d[3:0] = d[3:0] - 4'd1;
        end else begin
            d[3:0] = 4'd9;
            if (d[7:4] != 4'd0) begin
                d[7:4] = d[7:4] - 4'd1;
            end else begin
                d[7:4] = 4'd5;
                if (d[11:8] != 4'd0) begin
                    d[11:8] = d[11:8] - 4'd1;
                end else begin
                    d[11:8] = 4'd9;
                    if (d[15:12] != 4'd0) begin
                        d[15:12] = d[15:12] - 4'd1;
                    end else begin
                        d[15:12] = 4'd5;
                        if (d[19:16] != 4'd0) begin
                            d[19:16] = d[19:16] - 4'd1;
                        end else begin
                            d[19:16] = 4'd9;
                            d[23:20] = d[23:20] - 4'd1;
                        end
                    end
                end
            end
        end
        return d;
    endfunction

    // Tens of seconds and tens of minutes stop at 5; every other digit at 9.
    assign preset_ok = (preset[3:0]   <= 4'd9) && (preset[7:4]   <= 4'd5) &&
                       (preset[11:8]  <= 4'd9) && (preset[15:12] <= 4'd5) &&
                       (preset[19:16] <= 4'd9) && (preset[23:20] <= 4'd9);

    assign count_zero = (count == 24'd0);
    assign count_dec  = bcd_dec(count);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, next count and the one-cycle pulses; load > stop > start > count_1hz.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_nx  = state;
        count_nx  = count;
        reload_nx = reload;
        pulse_nx  = 1'b0;
        err_nx    = 1'b0;

        if (load) begin
            if (preset_ok) begin
                count_nx  = preset;
                reload_nx = preset;
                if (state == DONE) begin
                    state_nx = IDLE;
                end
            end else begin
                err_nx = 1'b1;
            end
        end else if (stop) begin
            if (state == RUN) begin
                state_nx = IDLE;
            end
        end else if (start) begin
            if ((state == IDLE) && !count_zero) begin
                state_nx = RUN;
            end
        end else if (count_1hz && (state == RUN)) begin
            if (count_zero) begin
                // Only reachable after a zero preset was loaded while running.
                state_nx = DONE;
            end else if (count_dec == 24'd0) begin
                pulse_nx = 1'b1;
                if (AUTO_RELOAD && (reload != 24'd0)) begin
                    count_nx = reload;
                end else begin
                    count_nx = 24'd0;
                    state_nx = DONE;
                end
            end else begin
                count_nx = count_dec;
            end
        end
    end

    // Digits, reload register and registered pulses.
    // NOTE: every register here is reset, since outputs must read 0 straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= 24'd0;
            reload        <= 24'd0;
            expired_pulse <= 1'b0;
            load_err      <= 1'b0;
        end else begin
            count         <= count_nx;
            reload        <= reload_nx;
            expired_pulse <= pulse_nx;
            load_err      <= err_nx;
        end
    end

    assign {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones} = count;
    assign running = (state == RUN);
    assign expired = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one instance per AUTO_RELOAD setting, both fed
// the same stimulus, each checked every cycle against a seconds-based model.

module tb_countdown_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        count_1hz = 1'b0;
    logic        load = 1'b0;
    logic [23:0] preset = 24'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;

    logic [3:0]  a_so, a_st, a_mo, a_mt, a_ho, a_ht;
    logic [3:0]  b_so, b_st, b_mo, b_mt, b_ho, b_ht;
    logic        a_run, a_exp, a_pls, a_err;
    logic        b_run, b_exp, b_pls, b_err;
    logic [23:0] a_dig, b_dig;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    countdown_timer #(.AUTO_RELOAD(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .count_1hz(count_1hz), .load(load), .preset(preset),
        .start(start), .stop(stop),
        .sec_ones(a_so), .sec_tens(a_st), .min_ones(a_mo), .min_tens(a_mt),
        .hr_ones(a_ho), .hr_tens(a_ht),
        .running(a_run), .expired(a_exp), .expired_pulse(a_pls), .load_err(a_err)
    );

    countdown_timer #(.AUTO_RELOAD(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .count_1hz(count_1hz), .load(load), .preset(preset),
        .start(start), .stop(stop),
        .sec_ones(b_so), .sec_tens(b_st), .min_ones(b_mo), .min_tens(b_mt),
        .hr_ones(b_ho), .hr_tens(b_ht),
        .running(b_run), .expired(b_exp), .expired_pulse(b_pls), .load_err(b_err)
    );

    assign a_dig = {a_ht, a_ho, a_mt, a_mo, a_st, a_so};
    assign b_dig = {b_ht, b_ho, b_mt, b_mo, b_st, b_so};

    // ---------------- behavioural model (time kept as plain seconds) ----------------
    typedef struct {
        int cnt;
        int rel;
        bit run;
        bit done;
        bit pulse;
        bit lerr;
    } model_t;

    model_t m [2];

    function automatic int to_secs(input logic [23:0] p);
        int h, mn, s;
        h  = int'(p[23:20]) * 10 + int'(p[19:16]);
        mn = int'(p[15:12]) * 10 + int'(p[11:8]);
        s  = int'(p[7:4])   * 10 + int'(p[3:0]);
        return h * 3600 + mn * 60 + s;
    endfunction

    function automatic logic [23:0] to_bcd(input int t);
        int h, mn, s;
        h  = t / 3600;
        mn = (t % 3600) / 60;
        s  = t % 60;
        return {4'(h / 10), 4'(h % 10), 4'(mn / 10), 4'(mn % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic bit legal(input logic [23:0] p);
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (p[k*4 +: 4] > 4'd9) ok = 1'b0;
        end
        if (p[7:4] > 4'd5 || p[15:12] > 4'd5) ok = 1'b0;
        return ok;
    endfunction

    function automatic model_t model_zero();
        model_t z;
        z.cnt = 0; z.rel = 0; z.run = 1'b0; z.done = 1'b0; z.pulse = 1'b0; z.lerr = 1'b0;
        return z;
    endfunction

    function automatic model_t model_next(input model_t s, input bit ar, input logic ld,
                                          input logic [23:0] p, input logic sp,
                                          input logic st, input logic tk);
        model_t n;
        n = s;
        n.pulse = 1'b0;
        n.lerr  = 1'b0;
        if (ld) begin
            if (legal(p)) begin
                n.cnt  = to_secs(p);
                n.rel  = n.cnt;
                n.done = 1'b0;
            end else begin
                n.lerr = 1'b1;
            end
        end else if (sp) begin
            n.run = 1'b0;
        end else if (st) begin
            if (!s.done && s.cnt != 0) n.run = 1'b1;
        end else if (tk && s.run) begin
            if (s.cnt == 0) begin
                n.run  = 1'b0;
                n.done = 1'b1;
            end else begin
                n.cnt = s.cnt - 1;
                if (n.cnt == 0) begin
                    n.pulse = 1'b1;
                    if (ar && s.rel != 0) begin
                        n.cnt = s.rel;
                    end else begin
                        n.run  = 1'b0;
                        n.done = 1'b1;
                    end
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m[0] <= model_zero();
            m[1] <= model_zero();
        end else begin
            m[0] <= model_next(m[0], 1'b0, load, preset, stop, start, count_1hz);
            m[1] <= model_next(m[1], 1'b1, load, preset, stop, start, count_1hz);
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, away from the rising edge, both instances against the model.
    always @(negedge clk) begin
        check("ar0 digits", a_dig, to_bcd(m[0].cnt));
        check("ar0 flags", {20'd0, a_run, a_exp, a_pls, a_err},
              {20'd0, m[0].run, m[0].done, m[0].pulse, m[0].lerr});
        check("ar1 digits", b_dig, to_bcd(m[1].cnt));
        check("ar1 flags", {20'd0, b_run, b_exp, b_pls, b_err},
              {20'd0, m[1].run, m[1].done, m[1].pulse, m[1].lerr});
    end

    // ---------------- stimulus ----------------
    // Called at a falling edge; holds the inputs for one full clock, returns at the next falling edge.
    task automatic drive(input logic ld, input logic [23:0] p, input logic sp,
                         input logic st, input logic tk);
        load = ld; preset = p; stop = sp; start = st; count_1hz = tk;
        @(negedge clk);
        load = 1'b0; stop = 1'b0; start = 1'b0; count_1hz = 1'b0;
    endtask

    task automatic do_load(input logic [23:0] p); drive(1'b1, p, 1'b0, 1'b0, 1'b0); endtask
    task automatic do_start();                    drive(1'b0, 24'd0, 1'b0, 1'b1, 1'b0); endtask
    task automatic do_stop();                     drive(1'b0, 24'd0, 1'b1, 1'b0, 1'b0); endtask
    task automatic do_tick();                     drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b1); endtask
    task automatic do_idle();                     drive(1'b0, 24'd0, 1'b0, 1'b0, 1'b0); endtask

    function automatic logic [23:0] rand_preset();
        logic [23:0] p;
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            p = 24'($urandom);
        end else if (r == 1) begin
            p = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)),
                 4'($urandom_range(0, 9)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        end else begin
            p = {12'd0, 4'($urandom_range(0, 1)), 4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
        end
        if (p == 24'd0) p = 24'h000001;
        return p;
    endfunction

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset digits", a_dig, 24'h000000);
        check("reset flags", {20'd0, a_run, a_exp, a_pls, a_err}, 24'd0);

        // Basic countdown from one minute.
        do_load(24'h000100);
        do_start();
        check("start running", {23'd0, a_run}, 24'd1);
        do_tick();
        check("first strobe", a_dig, 24'h000059);
        for (int i = 0; i < 58; i++) do_tick();
        check("strobe 59", a_dig, 24'h000001);
        do_tick();
        check("expiry digits", a_dig, 24'h000000);
        check("expiry flags", {20'd0, a_run, a_exp, a_pls, a_err}, 24'h000006);
        check("reload digits", b_dig, 24'h000100);
        check("reload flags", {20'd0, b_run, b_exp, b_pls, b_err}, 24'h00000a);
        do_idle();
        check("pulse one cycle", {23'd0, a_pls}, 24'd0);
        check("expired level", {23'd0, a_exp}, 24'd1);
        do_tick();
        check("strobe after done", a_dig, 24'h000000);

        // Borrow chain.
        do_load(24'h100000);
        check("load leaves done", {22'd0, a_run, a_exp}, 24'd0);
        do_start();
        do_tick();
        check("hour borrow", a_dig, 24'h095959);
        do_load(24'h001000);
        check("load in run", {23'd0, a_run}, 24'd1);
        do_tick();
        check("minute borrow", a_dig, 24'h000959);

        // Invalid and zero loads.
        do_load(24'h000060);
        check("load_err pulse", {23'd0, a_err}, 24'd1);
        check("invalid keeps digits", a_dig, 24'h000959);
        do_idle();
        check("load_err clears", {23'd0, a_err}, 24'd0);
        do_stop();
        do_load(24'h000000);
        do_start();
        check("zero start ignored", {23'd0, a_run}, 24'd0);

        // Priority and pause.
        do_load(24'h000030);
        do_start();
        drive(1'b0, 24'd0, 1'b1, 1'b0, 1'b1);
        check("stop beats strobe run", {23'd0, a_run}, 24'd0);
        check("stop beats strobe dig", a_dig, 24'h000030);
        do_start();
        check("resume", {23'd0, a_run}, 24'd1);
        drive(1'b1, 24'h000200, 1'b0, 1'b0, 1'b1);
        check("load beats strobe", a_dig, 24'h000200);
        check("load keeps run", {23'd0, a_run}, 24'd1);

        // Auto-reload from three seconds.
        do_stop();
        do_load(24'h000003);
        do_start();
        for (int i = 0; i < 3; i++) do_tick();
        check("ar1 reload digits", b_dig, 24'h000003);
        check("ar1 reload flags", {20'd0, b_run, b_exp, b_pls, b_err}, 24'h00000a);
        check("ar0 done", {22'd0, a_run, a_exp}, 24'd1);

        // Asynchronous reset mid-period.
        do_load(24'h012345);
        do_start();
        check("run at 01:23:45", a_dig, 24'h012345);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst digits", a_dig, 24'h000000);
        check("async rst flags", {20'd0, a_run, a_exp, a_pls, a_err}, 24'd0);
        check("async rst ar1", b_dig, 24'h000000);
        @(negedge clk);
        rst = 1'b0;
        do_tick();
        check("idle after reset", {23'd0, a_run}, 24'd0);
        check("no count after reset", a_dig, 24'h000000);

        // Randomized traffic; the per-cycle compare does the checking.
        for (int i = 0; i < 3000; i++) begin
            logic ld, sp, st, tk;
            ld = ($urandom_range(0, 99) < 6);
            sp = ($urandom_range(0, 99) < 3);
            st = ($urandom_range(0, 99) < 10);
            tk = ($urandom_range(0, 99) < 45);
            drive(ld, rand_preset(), sp, st, tk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Countdown counterpart to the stopwatch up-counter. It loads a BCD HH:MM:SS preset and decrements it once per 1 Hz strobe with seconds/minutes borrow. At 00:00:00 it stops and flags expiry, or reloads and continues if auto-reload is set. It sits beside the stopwatch counter, shares the same 1 Hz enable strobe, and drives the same six-digit display path.

## Interface
- AUTO_RELOAD, 0: 0 = stop in DONE at zero; 1 = reload stored preset at zero and keep running.
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- count_1hz  input  1  one-cycle enable strobe, once per second.
- load  input  1  one-cycle request to latch `preset`.
- preset  input  24  packed BCD {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
- start  input  1  one-cycle request to begin or resume counting.
- stop  input  1  one-cycle request to pause.
- sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens  output  4 each  current BCD count, registered.
- running  output  1  high while in RUN.
- expired  output  1  level, high while in DONE.
- expired_pulse  output  1  one-cycle pulse when the count reaches 00:00:00.
- load_err  output  1  one-cycle pulse when a `load` is rejected.

## Operation
- Reset value of every output is 0; state is IDLE; the stored preset is 00:00:00.
- Preset validity: every digit ≤ 9, and sec_tens ≤ 5, and min_tens ≤ 5.
  - Invalid preset: the load is ignored (digits, stored preset and state unchanged) and load_err pulses.
- Internal reload register holds the last valid preset.
- States:
  - IDLE: `load` (valid) copies preset to the digits and the reload register; stays IDLE. `start` with a nonzero count goes to RUN. `start` with a zero count is ignored.
  - RUN: each `count_1hz` decrements the count by one second. `stop` goes to IDLE with the count held.
    - `load` (valid) copies preset to the digits and reload register; stays RUN.
    - When a decrement produces 00:00:00: with AUTO_RELOAD=0, go to DONE; with AUTO_RELOAD=1, the same edge writes the reload register value to the digits instead of zero and stays RUN. expired_pulse fires in both cases.
    - Auto-reload with a reload value of 00:00:00: go to DONE.
  - DONE: digits hold 00:00:00; `start` and `count_1hz` are ignored. `load` (valid) goes to IDLE with the new preset.
- Same-cycle priority: load > stop > start > count_1hz. The lower-priority events in that cycle are dropped, not deferred.
- Decrement borrow chain:
  - sec_ones 0→9 borrows from sec_tens.
  - sec_tens 0→5 borrows from min_ones.
  - min_ones 0→9 borrows from min_tens.
  - min_tens 0→5 borrows from hr_ones.
  - hr_ones 0→9 borrows from hr_tens.
  - hr_tens decrements. The chain is never applied to 00:00:00 (no underflow).
- Range: 00:00:00 to 99:59:59.

## Timing
- All outputs are registered. A digit change appears one clock after the edge sampling the `count_1hz`, `load` or `start` cycle.
- running follows the state register: it rises the cycle after an accepted start and falls the cycle after an accepted stop or expiry.
- expired_pulse is high for exactly the one cycle in which the digits first show 00:00:00 (or the reloaded value under AUTO_RELOAD).
- expired rises in that same cycle and stays high until a valid load or reset.
- load_err is high for the single cycle after the rejected load.
- Asserting rst at any time, including mid-decrement, immediately clears all outputs and state without waiting for clk. The first update after release needs a new strobe.
- No combinational path from inputs to outputs.

## Test plan
- Basic countdown: load 00:01:00, start, 60 count_1hz strobes -> 00:00:59 after strobe 1. After strobe 60: 00:00:00, expired_pulse for 1 cycle, expired=1, running=0. Strobe 61 leaves the count at zero.
- Borrow chain: load 10:00:00, start, one strobe -> 09:59:59. Load 00:10:00, one strobe -> 00:09:59.
- Invalid and edge loads: load with sec_tens=6 -> load_err pulse, digits unchanged. Load 00:00:00 then start -> stays IDLE, running=0.
- Priority and pause: in RUN at 00:00:30, assert stop and count_1hz together -> IDLE, 00:00:30. Start -> RUN. Load 00:02:00 with count_1hz together -> 00:02:00, still RUN.
- Auto-reload (AUTO_RELOAD=1): load 00:00:03, start, 3 strobes -> expired_pulse, digits 00:00:03, running stays 1, expired stays 0.
- Asynchronous reset: assert rst mid-clock-period during RUN at 01:23:45 -> all digits and flags 0 before the next clk edge. After release, state is IDLE.
